calc2: RTL and testbench

- Four-port, tagged, two-operand 32-bit calculator: command unit of the calc2 block.
- Each port accepts add, subtract, shift-left and shift-right requests.
- Requests are queued per port and dispatched round-robin to one shared add/sub unit and one shifter.
- Each result returns on the requesting port with its tag; the calc2_bfm interface drives and monitors these ports.

---
 rtl/calc2_pkg.sv | 74 +++++++
 rtl/calc2_port_q.sv | 65 ++++++
 rtl/calc2.sv | 140 ++++++++++++++
 tb/tb_calc2.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// Shared types and constants for the calc2 four-port tagged calculator.
package calc2_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TAG_W   = 2;
  localparam int unsigned Q_DEPTH = 4;
  localparam int unsigned LAT     = 2;
  localparam int unsigned NPORT   = 4;
  localparam int unsigned CMD_W   = 4;

  typedef enum logic [CMD_W-1:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    ERR  = 2'd2
  } resp_e;

  // cmd is kept raw so invalid codes travel through the queue unchanged
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

  typedef struct packed {
    resp_e             resp;
    logic [DATA_W-1:0] data;
  } alu_t;

  typedef struct packed {
    logic              valid;
    logic [1:0]        port;
    resp_e             resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } rsp_t;

  function automatic alu_t alu(input req_t r);
    alu_t            res;
    logic [DATA_W:0] sum;
    res.resp = ERR;
    res.data = '0;
    sum      = {1'b0, r.op1} + {1'b0, r.op2};
    case (r.cmd)
      4'(ADD): if (!sum[DATA_W]) begin
        res.resp = OK;
        res.data = sum[DATA_W-1:0];
      end
      4'(SUB): if (r.op1 >= r.op2) begin
        res.resp = OK;
        res.data = r.op1 - r.op2;
      end
      4'(SHL): begin
        res.resp = OK;
        res.data = r.op1 << r.op2[4:0];
      end
      4'(SHR): begin
        res.resp = OK;
        res.data = r.op1 >> r.op2[4:0];
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc2_port_q.sv
// Per-port two-cycle command capture (cmd/tag/op1 then op2) feeding a small FIFO.
module calc2_port_q
  import calc2_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              pop_i,
  output logic              empty_o,
  output req_t              head_o
);

  localparam int unsigned PW = $clog2(Q_DEPTH);
  localparam int unsigned CW = $clog2(Q_DEPTH + 1);

  typedef enum logic {IDLE, WAIT_OP2} state_e;

  state_e            state_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] op1_q;
  req_t              mem_q [Q_DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [CW-1:0]     cnt_q;
  logic              push;

  // A request arriving while the FIFO is full is dropped without trace
  assign push    = (state_q == WAIT_OP2) && (cnt_q != CW'(Q_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      tag_q   <= '0;
      op1_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < Q_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_i != NOP) begin
          cmd_q   <= cmd_i;
          tag_q   <= tag_i;
          op1_q   <= data_i;
          state_q <= WAIT_OP2;
        end
        WAIT_OP2: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
      if (push) begin
        mem_q[wr_q] <= '{cmd: cmd_q, tag: tag_q, op1: op1_q, op2: data_i};
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_i) rd_q <= rd_q + PW'(1);
      if (push && !pop_i)      cnt_q <= cnt_q + CW'(1);
      else if (pop_i && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/calc2.sv
// calc2 command unit: four queued ports, round-robin dispatch, shared ALU, LAT-cycle response.
// Optional CALC2_SCAN_EN adds a scan_in -> scan_out flop.
module calc2
  import calc2_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [TAG_W-1:0]  req1_tag_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [TAG_W-1:0]  req2_tag_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [TAG_W-1:0]  req3_tag_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req4_data_in,
  input  logic [TAG_W-1:0]  req4_tag_in,
  output logic [1:0]        out_resp1,
  output logic [DATA_W-1:0] out_data1,
  output logic [TAG_W-1:0]  out_tag1,
  output logic [1:0]        out_resp2,
  output logic [DATA_W-1:0] out_data2,
  output logic [TAG_W-1:0]  out_tag2,
  output logic [1:0]        out_resp3,
  output logic [DATA_W-1:0] out_data3,
  output logic [TAG_W-1:0]  out_tag3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data4,
  output logic [TAG_W-1:0]  out_tag4
`ifdef CALC2_SCAN_EN
  ,
  input  logic              scan_in,
  output logic              scan_out
`endif
);

  logic [CMD_W-1:0]  cmd_in  [NPORT];
  logic [DATA_W-1:0] data_in [NPORT];
  logic [TAG_W-1:0]  tag_in  [NPORT];
  req_t              head    [NPORT];
  logic [NPORT-1:0]  empty, pop;

  logic [1:0]        rr_q, sel_idx, cand;
  logic              sel_valid;
  alu_t              alu_res;
  rsp_t              pipe_d;
  rsp_t              pipe_q  [LAT];
  resp_e             resp_q  [NPORT];
  logic [DATA_W-1:0] data_q  [NPORT];
  logic [TAG_W-1:0]  tag_q   [NPORT];

  assign cmd_in  = '{req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in};
  assign data_in = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};
  assign tag_in  = '{req1_tag_in,  req2_tag_in,  req3_tag_in,  req4_tag_in};

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    calc2_port_q u_q (
      .clk_i   (c_clk),
      .rst_i   (reset),
      .cmd_i   (cmd_in[g]),
      .data_i  (data_in[g]),
      .tag_i   (tag_in[g]),
      .pop_i   (pop[g]),
      .empty_o (empty[g]),
      .head_o  (head[g])
    );
  end

  // Search starts at rr_q, which always points just past the last port served
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = rr_q;
    cand      = '0;
    pop       = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      cand = rr_q + 2'(i);
      if (!sel_valid && !empty[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
    if (sel_valid) pop[sel_idx] = 1'b1;
  end

  assign alu_res = alu(head[sel_idx]);
  assign pipe_d  = '{valid: sel_valid, port: sel_idx, resp: alu_res.resp,
                     data: alu_res.data, tag: head[sel_idx].tag};

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      rr_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) pipe_q[i] <= '0;
      for (int unsigned p = 0; p < NPORT; p++) begin
        resp_q[p] <= NONE;
        data_q[p] <= '0;
        tag_q[p]  <= '0;
      end
    end else begin
      if (sel_valid) rr_q <= sel_idx + 2'd1;
      pipe_q[0] <= pipe_d;
      for (int unsigned i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
      for (int unsigned p = 0; p < NPORT; p++) begin
        if (pipe_q[LAT-1].valid && pipe_q[LAT-1].port == 2'(p)) begin
          resp_q[p] <= pipe_q[LAT-1].resp;
          data_q[p] <= pipe_q[LAT-1].data;
          tag_q[p]  <= pipe_q[LAT-1].tag;
        end else begin
          resp_q[p] <= NONE;
          data_q[p] <= '0;
          tag_q[p]  <= '0;
        end
      end
    end
  end

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = data_q[0];
  assign out_data2 = data_q[1];
  assign out_data3 = data_q[2];
  assign out_data4 = data_q[3];
  assign out_tag1  = tag_q[0];
  assign out_tag2  = tag_q[1];
  assign out_tag3  = tag_q[2];
  assign out_tag4  = tag_q[3];

`ifdef CALC2_SCAN_EN
  logic scan_q;
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) scan_q <= 1'b0;
    else       scan_q <= scan_in;
  end
  assign scan_out = scan_q;
`endif

endmodule

// File: tb/tb_calc2.sv
// Scoreboard bench for calc2: expectations queued per port at issue, popped on each response.
module tb_calc2;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    int unsigned at;
  } exp_t;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cmd_r  [4];
  logic [31:0] data_r [4];
  logic [1:0]  tag_r  [4];
  logic [1:0]  resp_o [4];
  logic [31:0] data_o [4];
  logic [1:0]  tag_o  [4];

  exp_t        sb [4][$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  bit          mon_en = 1'b1;
  logic [3:0]  cmds [6] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd15};

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  calc2 dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd_r[0]), .req1_data_in(data_r[0]), .req1_tag_in(tag_r[0]),
    .req2_cmd_in  (cmd_r[1]), .req2_data_in(data_r[1]), .req2_tag_in(tag_r[1]),
    .req3_cmd_in  (cmd_r[2]), .req3_data_in(data_r[2]), .req3_tag_in(tag_r[2]),
    .req4_cmd_in  (cmd_r[3]), .req4_data_in(data_r[3]), .req4_tag_in(tag_r[3]),
    .out_resp1    (resp_o[0]), .out_data1(data_o[0]), .out_tag1(tag_o[0]),
    .out_resp2    (resp_o[1]), .out_data2(data_o[1]), .out_tag2(tag_o[1]),
    .out_resp3    (resp_o[2]), .out_data3(data_o[2]), .out_tag3(tag_o[2]),
    .out_resp4    (resp_o[3]), .out_data4(data_o[3]), .out_tag4(tag_o[3])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic computed in wide unsigned form; returns {resp, data}
  function automatic logic [33:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] w;
    case (cmd)
      4'd1: begin
        w = 64'(a) + 64'(b);
        if (w > 64'hFFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, w[31:0]};
      end
      4'd2: begin
        if (b > a) return {2'd2, 32'd0};
        return {2'd1, a - b};
      end
      4'd5:    return {2'd1, a << b[4:0]};
      4'd6:    return {2'd1, a >> b[4:0]};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  task automatic go(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                    input logic [31:0] op1, input logic [33:0] exp,
                    input int unsigned lat, input bit track);
    exp_t e;
    cmd_r[p]  = cmd;
    tag_r[p]  = tag;
    data_r[p] = op1;
    if (track) begin
      e.resp = exp[33:32];
      e.data = exp[31:0];
      e.tag  = tag;
      e.at   = cyc + 1 + lat;
      sb[p].push_back(e);
    end
  endtask

  task automatic op2(input int p, input logic [31:0] v);
    cmd_r[p]  = 4'd0;
    data_r[p] = v;
  endtask

  function automatic int unsigned pending();
    int unsigned n = 0;
    for (int p = 0; p < 4; p++) n += sb[p].size();
    return n;
  endfunction

  task automatic drain();
    int unsigned n = 0;
    while (pending() != 0 && n < 60) begin
      @(negedge c_clk);
      n++;
    end
    check("drain_pending", 64'(pending()), 64'd0);
    repeat (2) @(negedge c_clk);
  endtask

  always @(negedge c_clk) begin : mon
    exp_t e;
    if (mon_en && !reset) begin
      for (int p = 0; p < 4; p++) begin
        if (resp_o[p] != 2'd0) begin
          if (sb[p].size() == 0) begin
            check($sformatf("unexpected_p%0d", p + 1), 64'(resp_o[p]), 64'd0);
          end else begin
            e = sb[p].pop_front();
            check($sformatf("p%0d_resp", p + 1), 64'(resp_o[p]), 64'(e.resp));
            check($sformatf("p%0d_data", p + 1), 64'(data_o[p]), 64'(e.data));
            check($sformatf("p%0d_tag", p + 1),  64'(tag_o[p]),  64'(e.tag));
            check($sformatf("p%0d_cycle", p + 1), 64'(cyc), 64'(e.at));
          end
        end
      end
    end
  end

  initial begin
    int unsigned seen;
    logic [3:0]  c;
    logic [31:0] a, b;
    int          p;
    for (int i = 0; i < 4; i++) begin
      cmd_r[i] = '0; data_r[i] = '0; tag_r[i] = '0;
    end
    repeat (3) @(negedge c_clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_resp%0d", i + 1), 64'(resp_o[i]), 64'd0);
      check($sformatf("rst_data%0d", i + 1), 64'(data_o[i]), 64'd0);
    end
    reset = 1'b0;

    @(negedge c_clk); go(0, 4'd1, 2'd0, 32'h5, {2'd1, 32'hC}, 4, 1);
    @(negedge c_clk); op2(0, 32'h7);
    @(negedge c_clk); go(1, 4'd1, 2'd3, 32'hFFFF_FFFF, {2'd2, 32'h0}, 4, 1);
    @(negedge c_clk); op2(1, 32'h1);
    @(negedge c_clk); go(2, 4'd2, 2'd1, 32'h3, {2'd2, 32'h0}, 4, 1);
    @(negedge c_clk); op2(2, 32'h4);
    @(negedge c_clk); go(2, 4'd2, 2'd2, 32'h10, {2'd1, 32'hC}, 4, 1);
    @(negedge c_clk); op2(2, 32'h4);
    @(negedge c_clk); go(3, 4'd5, 2'd0, 32'h1, {2'd1, 32'h8000_0000}, 4, 1);
    @(negedge c_clk); op2(3, 32'h1F);
    @(negedge c_clk); go(3, 4'd6, 2'd1, 32'h8000_0000, {2'd1, 32'h0800_0000}, 4, 1);
    @(negedge c_clk); op2(3, 32'h4);
    @(negedge c_clk); go(3, 4'd4, 2'd2, 32'h1234, {2'd2, 32'h0}, 4, 1);
    @(negedge c_clk); op2(3, 32'h1);
    drain();

    // Last port served was 4, so simultaneous requests come back 1,2,3,4
    @(negedge c_clk);
    for (int i = 0; i < 4; i++)
      go(i, 4'd1, 2'(i), 32'(i * 16 + 1), {2'd1, 32'(i * 16 + 1 + 100)}, 4 + i, 1);
    @(negedge c_clk);
    for (int i = 0; i < 4; i++) op2(i, 32'd100);
    drain();

    mon_en = 1'b0;
    @(negedge c_clk); go(3, 4'd1, 2'd1, 32'h1, 34'd0, 4, 0);
    @(negedge c_clk); op2(3, 32'h2);
    @(negedge c_clk);
    @(negedge c_clk);
    for (int i = 0; i < 3; i++) go(i, 4'd1, 2'(i), 32'h10, 34'd0, 4, 0);
    @(negedge c_clk);
    for (int i = 0; i < 3; i++) op2(i, 32'h20);
    @(negedge c_clk);
    check("pre_rst_resp4", 64'(resp_o[3]), 64'd1);
    check("pre_rst_data4", 64'(data_o[3]), 64'd3);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("midrst_resp%0d", i + 1), 64'(resp_o[i]), 64'd0);
      check($sformatf("midrst_data%0d", i + 1), 64'(data_o[i]), 64'd0);
      check($sformatf("midrst_tag%0d", i + 1),  64'(tag_o[i]),  64'd0);
    end
    repeat (2) @(negedge c_clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge c_clk);
      for (int i = 0; i < 4; i++) if (resp_o[i] != 2'd0) seen++;
    end
    check("no_resp_after_rst", 64'(seen), 64'd0);
    mon_en = 1'b1;
    @(negedge c_clk); go(1, 4'd2, 2'd2, 32'h10, {2'd1, 32'hC}, 4, 1);
    @(negedge c_clk); op2(1, 32'h4);
    drain();

    for (int k = 0; k < 12; k++) begin
      p = int'($urandom_range(0, 3));
      c = cmds[$urandom_range(0, 5)];
      a = $urandom;
      b = (k % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      @(negedge c_clk); go(p, c, 2'(k), a, model(c, a, b), 4, 1);
      @(negedge c_clk); op2(p, b);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
